// File: rtl/apb_reg_slave.sv
// -----------------------------------------------------------------------------
// apb_reg_slave
//
// APB completer holding eight 32-bit registers at byte offsets 0x00..0x1C.
// Registers 0..6 are read/write and clear on reset. Register 7 is read-only
// and returns ID_VALUE. Every transfer inserts WAIT_CYCLES wait states
// before PREADY is raised.
//
// Parameters
//   WAIT_CYCLES  wait states before PREADY in every transfer (0..15)
//   ID_VALUE     contents of read-only register 7
//
// Ports
//   PCLK     in   APB clock, rising edge active
//   PRESETn  in   asynchronous active-low reset
//   PSELx    in   completer select
//   PENABLE  in   access-phase strobe
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   32-bit byte address
//   PWDATA   in   32-bit write data
//   PRDATA   out  read data, non-zero only while completing a legal read
//   PREADY   out  transfer-complete strobe (combinational)
//   PSLVERR  out  transfer error, qualified by PREADY
// -----------------------------------------------------------------------------
module apb_reg_slave #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h4150_4231
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSELx,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam int         NUM_RW    = 7;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_capture;

  // Transfer attributes captured on the setup edge
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_write;

  logic [31:0] r_regs [NUM_RW];

  logic        w_setup;
  logic        w_xfer_phase;
  logic        w_ready;
  logic        w_complete;
  logic        w_legal;
  logic        w_ro_hit;
  logic        w_wr_en;
  logic [2:0]  w_idx;
  logic [31:0] w_rd_reg;

  // ---------------------------------------------------------------------------
  // Bus phase decode
  // ---------------------------------------------------------------------------
  assign w_setup      = PSELx & ~PENABLE;
  assign w_xfer_phase = PSELx &  PENABLE;
  assign w_ready      = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  assign w_complete   = w_ready & w_xfer_phase;

  // ---------------------------------------------------------------------------
  // Address decode on the captured address
  // ---------------------------------------------------------------------------
  assign w_idx    = r_addr[4:2];
  assign w_legal  = (r_addr[31:5] == 27'd0) && (r_addr[1:0] == 2'b00);
  assign w_ro_hit = (w_idx == 3'd7);
  assign w_wr_en  = w_complete & r_write & w_legal & ~w_ro_hit;

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // A select with PENABLE already high has skipped the setup phase and
        // is not a valid transfer start, so only a true setup is accepted.
        if (w_setup) begin
          w_state_nxt = S_ACCESS;
          w_cnt_nxt   = WAIT_LOAD;
          w_capture   = 1'b1;
        end
      end
      S_ACCESS: begin
        if (w_xfer_phase) begin
          if (w_ready) begin
            w_state_nxt = S_IDLE;
          end else begin
            // Not ready implies the counter is nonzero here.
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end else if (w_setup) begin
          // Aborted access that is itself a new setup: restart the transfer.
          w_state_nxt = S_ACCESS;
          w_cnt_nxt   = WAIT_LOAD;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM state and wait counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer capture (data path, no reset needed: only consumed in ACCESS)
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (w_capture) begin
      r_addr  <= PADDR;
      r_write <= PWRITE;
      r_wdata <= PWDATA;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: written only on the completion edge of a legal write
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_RW; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_wr_en) begin
      r_regs[w_idx] <= r_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and response outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd_reg = 32'd0;
    if (w_ro_hit) begin
      w_rd_reg = ID_VALUE;
    end else begin
      w_rd_reg = r_regs[w_idx];
    end
  end

  // PRESETn gating keeps the response quiet even in the reset delta before
  // the state register has been forced back to IDLE.
  assign PREADY  = PRESETn & w_ready;
  assign PSLVERR = PREADY & (~w_legal | (r_write & w_ro_hit));
  assign PRDATA  = (PREADY & ~r_write & w_legal) ? w_rd_reg : 32'd0;

endmodule

// File: tb/tb_apb_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_reg_slave
//
// Two completers are exercised side by side: u_w0 with WAIT_CYCLES=0 and
// u_w1 with WAIT_CYCLES=1, so the instance index equals its wait count.
// A reference model tracks each completer at transfer level (active flag,
// cycles elapsed since the setup edge, captured request, register array) and
// a compare process checks PREADY/PSLVERR/PRDATA on every falling edge.
// Directed scenarios add literal expectations; a random phase follows.
// -----------------------------------------------------------------------------
module tb_apb_reg_slave;

  localparam logic [31:0] ID = 32'h4150_4231;

  logic        clk = 1'b0;
  logic        rstn;
  always #5 clk = ~clk;

  logic [1:0]  psel, pen, pwr, prdy, perr;
  logic [31:0] paddr  [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];

  int n_cmp = 0;
  int n_err = 0;

  apb_reg_slave #(.WAIT_CYCLES(0), .ID_VALUE(ID)) u_w0 (
    .PCLK(clk), .PRESETn(rstn), .PSELx(psel[0]), .PENABLE(pen[0]),
    .PWRITE(pwr[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
    .PRDATA(prdata[0]), .PREADY(prdy[0]), .PSLVERR(perr[0])
  );

  apb_reg_slave #(.WAIT_CYCLES(1), .ID_VALUE(ID)) u_w1 (
    .PCLK(clk), .PRESETn(rstn), .PSELx(psel[1]), .PENABLE(pen[1]),
    .PWRITE(pwr[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
    .PRDATA(prdata[1]), .PREADY(prdy[1]), .PSLVERR(perr[1])
  );

  function automatic int wcof(input int d);
    return d;
  endfunction

  function automatic logic legal(input logic [31:0] a);
    return (a[31:5] == 27'd0) && (a[1:0] == 2'b00);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model
  logic        m_act  [2];
  int          m_age  [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wd   [2];
  logic        m_wr   [2];
  logic [31:0] m_mem  [2][8];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int d = 0; d < 2; d++) begin
        m_act[d] <= 1'b0;
        m_age[d] <= 0;
        for (int r = 0; r < 8; r++) m_mem[d][r] <= (r == 7) ? ID : 32'd0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_act[d] && psel[d] && pen[d] && m_age[d] >= wcof(d)) begin
          m_act[d] <= 1'b0;
          if (m_wr[d] && legal(m_addr[d]) && m_addr[d][4:2] != 3'd7)
            m_mem[d][m_addr[d][4:2]] <= m_wd[d];
        end else if (psel[d] && !pen[d]) begin
          m_act[d]  <= 1'b1;
          m_age[d]  <= 0;
          m_addr[d] <= paddr[d];
          m_wr[d]   <= pwr[d];
          m_wd[d]   <= pwdata[d];
        end else if (m_act[d] && psel[d] && pen[d]) begin
          m_age[d] <= m_age[d] + 1;
        end else begin
          m_act[d] <= 1'b0;
        end
      end
    end
  end

  function automatic logic exp_rdy(input int d);
    return rstn && m_act[d] && (m_age[d] >= wcof(d));
  endfunction

  function automatic logic exp_err(input int d);
    return exp_rdy(d) && (!legal(m_addr[d]) || (m_wr[d] && m_addr[d][4:2] == 3'd7));
  endfunction

  function automatic logic [31:0] exp_dat(input int d);
    if (exp_rdy(d) && !m_wr[d] && legal(m_addr[d])) return m_mem[d][m_addr[d][4:2]];
    return 32'd0;
  endfunction

  // Cycle-by-cycle compare
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d PREADY", d), prdy[d], exp_rdy(d));
      chk($sformatf("u%0d PSLVERR", d), perr[d], exp_err(d));
      chk($sformatf("u%0d PRDATA", d), prdata[d], exp_dat(d));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after a rising edge; returns at #1 after the completion edge
  // with the bus released, so an immediate next call is back-to-back.
  task automatic xfer(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int waits);
    logic done;
    psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = w; paddr[d] = a; pwdata[d] = wd;
    tick();
    pen[d] = 1'b1;
    waits = 0; rd = 32'd0; er = 1'b0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (prdy[d]) begin
        rd = prdata[d]; er = perr[d]; done = 1'b1;
      end else begin
        waits++;
        tick();
      end
    end
    chk($sformatf("u%0d completion", d), done, 1'b1);
    tick();
    psel[d] = 1'b0; pen[d] = 1'b0;
  endtask

  // Setup, enter access, then drop PENABLE before completion.
  task automatic xfer_abort(input int d, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic keep_sel);
    psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = w; paddr[d] = a; pwdata[d] = wd;
    tick();
    pen[d] = 1'b1;
    @(negedge clk);
    #1;
    pen[d] = 1'b0;
    psel[d] = keep_sel;
    tick();
    psel[d] = 1'b0; pen[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a, wd;
    logic        er, w;
    int          waits, d;

    rstn = 1'b0;
    psel = '0; pen = '0; pwr = '0;
    for (int i = 0; i < 2; i++) begin paddr[i] = '0; pwdata[i] = '0; end
    tick(); tick(); tick();
    chk("reset PREADY", {30'd0, prdy}, 32'd0);
    chk("reset PSLVERR", {30'd0, perr}, 32'd0);
    chk("reset PRDATA u1", prdata[1], 32'd0);
    rstn = 1'b1;
    tick();

    // One-wait write then read back
    xfer(1, 1'b1, 32'h08, 32'hDEADBEEF, rd, er, waits);
    chk("w1 write waits", waits, 1);
    chk("w1 write err", er, 1'b0);
    xfer(1, 1'b0, 32'h08, 32'h0, rd, er, waits);
    chk("w1 read waits", waits, 1);
    chk("w1 read err", er, 1'b0);
    chk("w1 read data", rd, 32'hDEADBEEF);

    // Zero-wait ID register access
    xfer(0, 1'b0, 32'h1C, 32'h0, rd, er, waits);
    chk("w0 id waits", waits, 0);
    chk("w0 id data", rd, ID);
    chk("w0 id err", er, 1'b0);
    xfer(0, 1'b1, 32'h1C, 32'hFFFF_FFFF, rd, er, waits);
    chk("w0 id write err", er, 1'b1);
    xfer(0, 1'b0, 32'h1C, 32'h0, rd, er, waits);
    chk("w0 id after write", rd, ID);

    // Illegal addresses
    xfer(1, 1'b1, 32'h20, 32'h1111_1111, rd, er, waits);
    chk("ill 0x20 write err", er, 1'b1);
    xfer(1, 1'b0, 32'h20, 32'h0, rd, er, waits);
    chk("ill 0x20 read err", er, 1'b1);
    chk("ill 0x20 read data", rd, 32'd0);
    xfer(1, 1'b1, 32'h06, 32'h2222_2222, rd, er, waits);
    chk("ill 0x06 write err", er, 1'b1);
    xfer(1, 1'b0, 32'h06, 32'h0, rd, er, waits);
    chk("ill 0x06 read err", er, 1'b1);
    chk("ill 0x06 read data", rd, 32'd0);
    xfer(1, 1'b0, 32'h08, 32'h0, rd, er, waits);
    chk("ill reg2 intact", rd, 32'hDEADBEEF);
    xfer(1, 1'b0, 32'h00, 32'h0, rd, er, waits);
    chk("ill reg0 intact", rd, 32'd0);
    xfer(1, 1'b0, 32'h04, 32'h0, rd, er, waits);
    chk("ill reg1 intact", rd, 32'd0);

    // Select with PENABLE but no setup phase is ignored
    psel[1] = 1'b1; pen[1] = 1'b1; pwr[1] = 1'b1; paddr[1] = 32'h0C; pwdata[1] = 32'h5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nosetup PREADY", prdy[1], 1'b0);
      tick();
    end
    psel[1] = 1'b0; pen[1] = 1'b0;
    xfer(1, 1'b0, 32'h0C, 32'h0, rd, er, waits);
    chk("nosetup reg3", rd, 32'd0);

    // Abort during the wait cycle
    psel[1] = 1'b1; pen[1] = 1'b0; pwr[1] = 1'b1; paddr[1] = 32'h04; pwdata[1] = 32'h1234;
    tick();
    pen[1] = 1'b1;
    @(negedge clk);
    chk("abort wait PREADY", prdy[1], 1'b0);
    #1 pen[1] = 1'b0;
    tick();
    psel[1] = 1'b0;
    @(negedge clk);
    chk("abort resetup PREADY", prdy[1], 1'b0);
    tick();
    @(negedge clk);
    chk("abort idle PREADY", prdy[1], 1'b0);
    tick();
    xfer(1, 1'b0, 32'h04, 32'h0, rd, er, waits);
    chk("abort reg1", rd, 32'd0);
    chk("abort next waits", waits, 1);
    chk("abort next err", er, 1'b0);

    // Back-to-back writes to all RW registers, then read back
    for (int dd = 0; dd < 2; dd++) begin
      for (int i = 0; i < 7; i++) begin
        xfer(dd, 1'b1, 32'(i * 4), 32'(i + 1) * 32'h0101_0101, rd, er, waits);
        chk($sformatf("b2b u%0d w%0d waits", dd, i), waits, dd);
        chk($sformatf("b2b u%0d w%0d err", dd, i), er, 1'b0);
      end
      for (int i = 0; i < 7; i++) begin
        xfer(dd, 1'b0, 32'(i * 4), 32'h0, rd, er, waits);
        chk($sformatf("b2b u%0d r%0d", dd, i), rd, 32'(i + 1) * 32'h0101_0101);
      end
    end

    // Reset during a transfer on both instances
    psel = 2'b11; pen = 2'b00;
    pwr[1] = 1'b1; paddr[1] = 32'h00; pwdata[1] = 32'hCAFE_F00D;
    pwr[0] = 1'b0; paddr[0] = 32'h1C;
    tick();
    pen = 2'b11;
    @(negedge clk);
    chk("rst pre u1 PREADY", prdy[1], 1'b0);
    chk("rst pre u0 PREADY", prdy[0], 1'b1);
    chk("rst pre u0 PRDATA", prdata[0], ID);
    #2 rstn = 1'b0;
    #1;
    chk("rst now PREADY", {30'd0, prdy}, 32'd0);
    chk("rst now PSLVERR", {30'd0, perr}, 32'd0);
    chk("rst now u0 PRDATA", prdata[0], 32'd0);
    tick(); tick();
    psel = 2'b00; pen = 2'b00;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    xfer(1, 1'b0, 32'h00, 32'h0, rd, er, waits);
    chk("post rst u1 reg0", rd, 32'd0);
    chk("post rst u1 waits", waits, 1);
    xfer(1, 1'b0, 32'h08, 32'h0, rd, er, waits);
    chk("post rst u1 reg2", rd, 32'd0);
    xfer(0, 1'b0, 32'h18, 32'h0, rd, er, waits);
    chk("post rst u0 reg6", rd, 32'd0);

    // Random traffic, checked by the compare process
    for (int n = 0; n < 400; n++) begin
      d  = int'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 7))
        6: a = 32'h20 + (32'($urandom_range(0, 7)) << 2);
        7: a = $urandom;
        default: a = 32'($urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) xfer_abort(d, w, a, wd, 1'($urandom_range(0, 1)));
      else xfer(d, w, a, wd, rd, er, waits);
      if ($urandom_range(0, 3) == 0) tick();
    end

    // Final sweep of every register on both instances
    for (int dd = 0; dd < 2; dd++)
      for (int i = 0; i < 8; i++)
        xfer(dd, 1'b0, 32'(i * 4), 32'h0, rd, er, waits);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
